// File: rtl/mux2_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux2_arb_pkg
//   Shared types and constants for the two-source stream arbiter that drives
//   the HDMUXB2DL inverting 2:1 mux bank.
//   - arb_state_e : arbiter lock state (idle, locked to A0, locked to A1)
//   - SRC_A0/SRC_A1 : select encoding driven onto the cell bank SL pin
//   - BURST_MAX   : largest supported burst length
// -----------------------------------------------------------------------------
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

    localparam logic SRC_A0 = 1'b0;
    localparam logic SRC_A1 = 1'b1;

    localparam int BURST_MAX = 15;

    // Lock state that corresponds to holding the mux on a given source.
    function automatic arb_state_e lock_of(input logic src);
        return (src == SRC_A1) ? ST_LOCK1 : ST_LOCK0;
    endfunction

endpackage

// File: rtl/HDMUXB2DL.sv
// -----------------------------------------------------------------------------
// HDMUXB2DL
//   Behavioural view of the library inverting 2:1 mux cell. The library view
//   replaces this at implementation; the function is Z = ~(SL ? A1 : A0).
// Ports
//   A0 in 1  data input selected when SL=0
//   A1 in 1  data input selected when SL=1
//   SL in 1  select
//   Z  out 1 inverted selected data
// -----------------------------------------------------------------------------
module HDMUXB2DL (
    input  logic A0,
    input  logic A1,
    input  logic SL,
    output logic Z
);

    assign Z = ~(SL ? A1 : A0);

endmodule

// File: rtl/mux2_inv_bank.sv
// -----------------------------------------------------------------------------
// mux2_inv_bank
//   W HDMUXB2DL cells sharing one select line. Purely structural.
// Ports
//   a0_i  in  W  data routed to the cells' A0 pins
//   a1_i  in  W  data routed to the cells' A1 pins
//   sl_i  in  1  shared select for every cell
//   zn_o  out W  inverted selected data, ~(sl_i ? a1_i : a0_i)
// -----------------------------------------------------------------------------
module mux2_inv_bank #(
    parameter int W = 8
) (
    input  logic [W-1:0] a0_i,
    input  logic [W-1:0] a1_i,
    input  logic         sl_i,
    output logic [W-1:0] zn_o
);

    for (genvar i = 0; i < W; i++) begin : g_cell
        HDMUXB2DL u_cell (
            .A0 (a0_i[i]),
            .A1 (a1_i[i]),
            .SL (sl_i),
            .Z  (zn_o[i])
        );
    end

endmodule

// File: rtl/mux2_stream_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_stream_arbiter
//   Two-source valid/ready arbiter feeding an inverting HDMUXB2DL bank and a
//   one-deep output register. Round-robin between sources, with the winner
//   allowed up to BURST consecutive beats before the other source gets a turn.
// Parameters
//   W      data width (one mux cell per bit)
//   BURST  max consecutive beats per grant, 1..BURST_MAX (1 = pure round-robin)
// Ports
//   CK      in  1  clock, rising edge
//   RN      in  1  asynchronous active-low reset
//   A0_D    in  W  source 0 data
//   A0_VLD  in  1  source 0 valid
//   A0_RDY  out 1  source 0 ready
//   A1_D    in  W  source 1 data
//   A1_VLD  in  1  source 1 valid
//   A1_RDY  out 1  source 1 ready
//   Z_D     out W  registered output data, true polarity
//   Z_VLD   out 1  output valid
//   Z_RDY   in  1  downstream ready
//   SL_O    out 1  select currently driven to the cell bank
// -----------------------------------------------------------------------------
module mux2_stream_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int W     = 8,
    parameter int BURST = 4
) (
    input  logic         CK,
    input  logic         RN,
    input  logic [W-1:0] A0_D,
    input  logic         A0_VLD,
    output logic         A0_RDY,
    input  logic [W-1:0] A1_D,
    input  logic         A1_VLD,
    output logic         A1_RDY,
    output logic [W-1:0] Z_D,
    output logic         Z_VLD,
    input  logic         Z_RDY,
    output logic         SL_O
);

    // Out-of-range BURST values are clamped into 1..BURST_MAX.
    localparam int BURST_EFF = (BURST < 1) ? 1 :
                               (BURST > BURST_MAX) ? BURST_MAX : BURST;
    localparam int CW        = $clog2(BURST_EFF + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_EFF);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          sl_q;
    logic          z_vld_q;
    logic [W-1:0]  z_d_q;

    logic          free;
    logic          lock_ok;
    logic          lock_src;
    logic          fresh_vld;
    logic          fresh_src;
    logic          grant_vld;
    logic          grant_src;
    logic          sel;
    logic          load;
    logic          sl_out;
    logic [W-1:0]  zc;

    // Output register can accept a beat when empty or draining this cycle.
    assign free = !z_vld_q | Z_RDY;

    // NOTE: every signal written in this block gets a default first, so no
    //       path leaves a value unassigned and no latch is inferred.
    always_comb begin
        lock_ok   = 1'b0;
        lock_src  = SRC_A0;
        fresh_vld = A0_VLD | A1_VLD;
        fresh_src = SRC_A0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;

        // A held lock continues while its source is valid and the burst is
        // not used up. cnt_q never exceeds CNT_MAX because it only increments
        // under this guard, so it saturates without wrapping.
        case (state_q)
            ST_LOCK0: begin
                lock_src = SRC_A0;
                lock_ok  = A0_VLD && (cnt_q < CNT_MAX);
            end
            ST_LOCK1: begin
                lock_src = SRC_A1;
                lock_ok  = A1_VLD && (cnt_q < CNT_MAX);
            end
            default: begin
                lock_src = SRC_A0;
                lock_ok  = 1'b0;
            end
        endcase

        // Fresh arbitration, used from idle and whenever a lock ends: the lone
        // valid source wins, a tie goes to the source that did not win last.
        // A source whose burst ran out with no competitor starts a new burst
        // in the same cycle, so a single source streams without bubbles.
        if (A0_VLD && A1_VLD) begin
            fresh_src = ~last_q;
        end else if (A1_VLD) begin
            fresh_src = SRC_A1;
        end else begin
            fresh_src = SRC_A0;
        end

        grant_vld = lock_ok | fresh_vld;
        grant_src = lock_ok ? lock_src : fresh_src;

        // With nothing granted the select holds, so the cell bank stays quiet.
        sel  = grant_vld ? grant_src : sl_q;
        load = free & grant_vld;

        // Lock state only moves when the output register is free; a stalled
        // output holds the lock and the beat count.
        if (load) begin
            state_d = lock_of(grant_src);
            cnt_d   = lock_ok ? (cnt_q + CNT_ONE) : CNT_ONE;
            last_d  = grant_src;
        end else if (free) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // Select and readies are forced low while reset is asserted, whatever
    // the sources present. Only the source the select points at sees ready.
    assign sl_out = RN & sel;
    assign A0_RDY = RN & free & (sel == SRC_A0);
    assign A1_RDY = RN & free & (sel == SRC_A1);

    mux2_inv_bank #(
        .W (W)
    ) u_bank (
        .a0_i (A0_D),
        .a1_i (A1_D),
        .sl_i (sl_out),
        .zn_o (zc)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    //       samples the pre-edge values regardless of statement order.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= SRC_A1;
            sl_q    <= SRC_A0;
            z_vld_q <= 1'b0;
            z_d_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sl_q    <= sel;
            // Drain and load on the same edge keeps Z_VLD high.
            if (load) begin
                z_vld_q <= 1'b1;
                z_d_q   <= ~zc;
            end else if (Z_RDY) begin
                z_vld_q <= 1'b0;
            end
        end
    end

    assign Z_D   = z_d_q;
    assign Z_VLD = z_vld_q;
    assign SL_O  = sl_out;

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2_stream_arbiter
//   Two arbiters (BURST=4 and BURST=1) share the same stimulus. Directed
//   vectors and hand-written sequences cover locking, backpressure, reset and
//   full-rate streaming; a random phase compares both against a reference
//   model built from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_mux2_stream_arbiter;

    localparam int W = 8;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic         ck;
    logic         rn;
    logic [W-1:0] a0_d, a1_d;
    logic         a0_vld, a1_vld, z_rdy;

    logic [W-1:0] z_d4, z_d1;
    logic         z_vld4, z_vld1;
    logic         rdy0_4, rdy1_4, rdy0_1, rdy1_1;
    logic         sl4, sl1;

    int n_checks = 0;
    int n_err    = 0;

    mux2_stream_arbiter #(.W(W), .BURST(4)) u_dut4 (
        .CK(ck), .RN(rn),
        .A0_D(a0_d), .A0_VLD(a0_vld), .A0_RDY(rdy0_4),
        .A1_D(a1_d), .A1_VLD(a1_vld), .A1_RDY(rdy1_4),
        .Z_D(z_d4), .Z_VLD(z_vld4), .Z_RDY(z_rdy), .SL_O(sl4)
    );

    mux2_stream_arbiter #(.W(W), .BURST(1)) u_dut1 (
        .CK(ck), .RN(rn),
        .A0_D(a0_d), .A0_VLD(a0_vld), .A0_RDY(rdy0_1),
        .A1_D(a1_d), .A1_VLD(a1_vld), .A1_RDY(rdy1_1),
        .Z_D(z_d1), .Z_VLD(z_vld1), .Z_RDY(z_rdy), .SL_O(sl1)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // ---------------------------------------------------------------- checks
    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // --------------------------------------------------------------- stimulus
    task automatic drive(input logic v0, input logic [7:0] d0,
                         input logic v1, input logic [7:0] d1, input logic zr);
        a0_vld = v0;
        a0_d   = d0;
        a1_vld = v1;
        a1_d   = d1;
        z_rdy  = zr;
    endtask

    // Leaves the bench at posedge+1 with idle inputs, ready for the next drive.
    task automatic do_reset();
        drive(L, 8'h00, L, 8'h00, H);
        rn = 1'b0;
        repeat (2) @(posedge ck);
        @(negedge ck);
        rn = 1'b1;
        @(posedge ck);
        #1;
    endtask

    // ---------------------------------------------------------- vector table
    typedef struct {
        logic       a0_vld;
        logic [7:0] a0_d;
        logic       a1_vld;
        logic [7:0] a1_d;
        logic       z_rdy;
        logic       exp_rdy0;
        logic       exp_rdy1;
        logic       exp_sl;
        logic       exp_zvld;
        logic [7:0] exp_zd;
    } vec_t;

    function automatic vec_t mk(input logic v0, input logic [7:0] d0,
                                input logic v1, input logic [7:0] d1, input logic zr,
                                input logic r0, input logic r1, input logic sl,
                                input logic zv, input logic [7:0] zd);
        vec_t v;
        v.a0_vld = v0; v.a0_d = d0; v.a1_vld = v1; v.a1_d = d1; v.z_rdy = zr;
        v.exp_rdy0 = r0; v.exp_rdy1 = r1; v.exp_sl = sl;
        v.exp_zvld = zv; v.exp_zd = zd;
        return v;
    endfunction

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    // -------------------------------------------------------- reference model
    // Per instance: who owns the mux, beats in the current burst, last winner,
    // where the select points, and the contents of the output register.
    int         m_owner [2];
    int         m_run   [2];
    int         m_last  [2];
    int         m_ptr   [2];
    logic       m_vld   [2];
    logic [7:0] m_d     [2];
    int         m_burst [2] = '{4, 1};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_run[k]   = 0;
            m_last[k]  = 1;
            m_ptr[k]   = 0;
            m_vld[k]   = 1'b0;
            m_d[k]     = 8'h00;
        end
    endtask

    function automatic logic src_valid(input int s);
        return (s == 0) ? a0_vld : a1_vld;
    endfunction

    function automatic int winner(input int k);
        if (m_owner[k] >= 0 && src_valid(m_owner[k]) && m_run[k] < m_burst[k])
            return m_owner[k];
        if (a0_vld && a1_vld) return 1 - m_last[k];
        if (a0_vld) return 0;
        if (a1_vld) return 1;
        return -1;
    endfunction

    // Called at the negative edge: compares pre-edge outputs, then advances
    // the model through the coming rising edge.
    task automatic model_cycle(input int k);
        int         w;
        int         ptr;
        logic       free;
        logic       a_r0, a_r1, a_sl, a_zv;
        logic [7:0] a_zd;
        w    = winner(k);
        ptr  = (w >= 0) ? w : m_ptr[k];
        free = !m_vld[k] || z_rdy;
        a_r0 = (k == 0) ? rdy0_4 : rdy0_1;
        a_r1 = (k == 0) ? rdy1_4 : rdy1_1;
        a_sl = (k == 0) ? sl4    : sl1;
        a_zv = (k == 0) ? z_vld4 : z_vld1;
        a_zd = (k == 0) ? z_d4   : z_d1;
        chk_bit($sformatf("rand b%0d rdy0", m_burst[k]), a_r0, free && ptr == 0);
        chk_bit($sformatf("rand b%0d rdy1", m_burst[k]), a_r1, free && ptr == 1);
        chk_bit($sformatf("rand b%0d sl", m_burst[k]), a_sl, ptr == 1);
        chk_bit($sformatf("rand b%0d z_vld", m_burst[k]), a_zv, m_vld[k]);
        chk_byte($sformatf("rand b%0d z_d", m_burst[k]), a_zd, m_d[k]);
        if (free && w >= 0) begin
            m_run[k]   = (w == m_owner[k] && m_run[k] < m_burst[k]) ? m_run[k] + 1 : 1;
            m_owner[k] = w;
            m_last[k]  = w;
            m_vld[k]   = 1'b1;
            m_d[k]     = (w == 1) ? a1_d : a0_d;
        end else if (free) begin
            m_owner[k] = -1;
            m_run[k]   = 0;
            m_vld[k]   = 1'b0;
        end
        m_ptr[k] = ptr;
    endtask

    // ------------------------------------------------------------------ main
    initial begin : main
        int sent;
        int got;

        //               a0v a0d    a1v a1d    zr | rdy0 rdy1 sl | zv zd
        vecs[0]  = mk(H, 8'h01, H, 8'h11, H, H, L, L, H, 8'h01); // tie, A0 first
        vecs[1]  = mk(H, 8'h02, H, 8'h11, H, H, L, L, H, 8'h02); // lock beat 2
        vecs[2]  = mk(H, 8'h03, H, 8'h11, H, H, L, L, H, 8'h03); // lock beat 3
        vecs[3]  = mk(H, 8'h04, H, 8'h11, H, H, L, L, H, 8'h04); // lock beat 4
        vecs[4]  = mk(H, 8'h05, H, 8'h11, H, L, H, H, H, 8'h11); // burst done
        vecs[5]  = mk(H, 8'h05, H, 8'h12, L, L, L, H, H, 8'h11); // stall 1
        vecs[6]  = mk(H, 8'h05, H, 8'h12, L, L, L, H, H, 8'h11); // stall 2
        vecs[7]  = mk(H, 8'h05, H, 8'h12, L, L, L, H, H, 8'h11); // stall 3
        vecs[8]  = mk(H, 8'h05, H, 8'h12, L, L, L, H, H, 8'h11); // stall 4
        vecs[9]  = mk(H, 8'h05, H, 8'h12, L, L, L, H, H, 8'h11); // stall 5
        vecs[10] = mk(H, 8'h05, H, 8'h12, H, L, H, H, H, 8'h12); // lock kept
        vecs[11] = mk(H, 8'h05, L, 8'h12, H, H, L, L, H, 8'h05); // owner drops
        vecs[12] = mk(L, 8'h05, L, 8'h12, L, L, L, L, H, 8'h05); // hold, stalled
        vecs[13] = mk(L, 8'h05, L, 8'h12, H, H, L, L, L, 8'h05); // drain, idle
        vecs[14] = mk(L, 8'h05, H, 8'hFF, H, L, H, H, H, 8'hFF); // A1 only FF
        vecs[15] = mk(L, 8'h05, H, 8'h00, H, L, H, H, H, 8'h00); // A1 only 00
        vecs[16] = mk(L, 8'h05, L, 8'h00, H, L, H, H, L, 8'h00); // sl holds 1
        vecs[17] = mk(H, 8'h21, H, 8'h22, H, H, L, L, H, 8'h21); // tie -> !last

        // Reset state with both sources requesting.
        rn = 1'b0;
        drive(H, 8'h3C, H, 8'hA5, H);
        #12;
        chk_bit("reset z_vld", z_vld4, L);
        chk_byte("reset z_d", z_d4, 8'h00);
        chk_bit("reset rdy0", rdy0_4, L);
        chk_bit("reset rdy1", rdy1_4, L);
        chk_bit("reset sl", sl4, L);

        // Directed vectors on the BURST=4 instance.
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].a0_vld, vecs[i].a0_d, vecs[i].a1_vld, vecs[i].a1_d, vecs[i].z_rdy);
            @(negedge ck);
            chk_bit($sformatf("vec%0d rdy0", i), rdy0_4, vecs[i].exp_rdy0);
            chk_bit($sformatf("vec%0d rdy1", i), rdy1_4, vecs[i].exp_rdy1);
            chk_bit($sformatf("vec%0d sl", i), sl4, vecs[i].exp_sl);
            @(posedge ck);
            #1;
            chk_bit($sformatf("vec%0d z_vld", i), z_vld4, vecs[i].exp_zvld);
            chk_byte($sformatf("vec%0d z_d", i), z_d4, vecs[i].exp_zd);
        end

        // BURST=1 alternation; seven beats so A0 was the last winner.
        do_reset();
        drive(H, 8'h3C, H, 8'hA5, H);
        for (int i = 0; i < 7; i++) begin
            @(negedge ck);
            chk_bit($sformatf("rr%0d sl", i), sl1, (i % 2) == 1);
            @(posedge ck);
            #1;
            chk_byte($sformatf("rr%0d z_d", i), z_d1, ((i % 2) == 1) ? 8'hA5 : 8'h3C);
        end

        // Reset mid-traffic, away from the clock edge.
        #2;
        rn = 1'b0;
        #1;
        chk_bit("midrst z_vld", z_vld1, L);
        chk_byte("midrst z_d", z_d1, 8'h00);
        chk_bit("midrst rdy0", rdy0_1, L);
        chk_bit("midrst rdy1", rdy1_1, L);
        chk_bit("midrst sl", sl1, L);
        chk_bit("midrst b4 z_vld", z_vld4, L);
        @(posedge ck);
        @(negedge ck);
        rn = 1'b1;
        #1;
        chk_bit("post-rst sl", sl1, L);
        chk_bit("post-rst rdy0", rdy0_1, H);
        chk_bit("post-rst rdy1", rdy1_1, L);
        @(posedge ck);
        #1;
        chk_bit("post-rst z_vld", z_vld1, H);
        chk_byte("post-rst z_d", z_d1, 8'h3C);
        chk_byte("post-rst b4 z_d", z_d4, 8'h3C);

        // Full rate single source: simultaneous drain and load, no bubbles.
        do_reset();
        sent = 0;
        got  = 0;
        for (int c = 0; c < 101; c++) begin
            drive(H, 8'(sent), L, 8'h00, H);
            @(negedge ck);
            if (z_vld4) begin
                chk_byte($sformatf("stream beat%0d", got), z_d4, 8'(got));
                got++;
            end
            if (rdy0_4) sent++;
            @(posedge ck);
            #1;
        end
        chk_int("stream beats out", got, 100);
        chk_int("stream beats in", sent, 101);

        // Random traffic against the reference model, both instances.
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 3) != 0);
            @(negedge ck);
            model_cycle(0);
            model_cycle(1);
            @(posedge ck);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
